nn_layer2_seq: RTL



---
 rtl/nn_pkg.sv | 33 +++
 rtl/nn_hardtanh.sv | 22 ++
 rtl/nn_layer2_seq.sv | 114 +++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared constants, state encoding and saturation helper for the small NN datapath.
// Layer-2 coefficients live here so every instance agrees on the default network.
package nn_pkg;

    localparam int ACT_MIN  = -256;
    localparam int ACT_MAX  = 255;
    localparam int L2_SUM_W = 23;

    // Weight k sits in bits [k*10 +: 10]; listed here from k=5 down to k=0.
    localparam logic [59:0] L2_WEIGHTS = {10'h3F0, 10'h021, 10'h07F,
                                          10'h3C8, 10'h012, 10'h055};
    localparam logic signed [15:0] L2_BIAS = 16'sh0040;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_BIAS = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic signed [L2_SUM_W-1:0] SAT_HI = 23'sd32767;
    localparam logic signed [L2_SUM_W-1:0] SAT_LO = -23'sd32768;

    function automatic logic signed [15:0] sat16(input logic signed [L2_SUM_W-1:0] x);
        if (x > SAT_HI)
            return 16'sh7FFF;
        else if (x < SAT_LO)
            return 16'sh8000;
        else
            return x[15:0];
    endfunction

endpackage

// File: rtl/nn_hardtanh.sv
// Hard-tanh clamp: narrows a wide signed pre-activation into the signed activation range.
// Purely combinational so it can sit directly in front of a capture register.
module nn_hardtanh
    import nn_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int ACT_W = 9,
    parameter int LO    = ACT_MIN,
    parameter int HI    = ACT_MAX
) (
    input  logic signed [IN_W-1:0]  x_i,
    output logic signed [ACT_W-1:0] y_o
);

    localparam logic signed [IN_W-1:0] LO_X = IN_W'(LO);
    localparam logic signed [IN_W-1:0] HI_X = IN_W'(HI);

    assign y_o = (x_i > HI_X) ? ACT_W'(HI) :
                 (x_i < LO_X) ? ACT_W'(LO) :
                                x_i[ACT_W-1:0];

endmodule

// File: rtl/nn_layer2_seq.sv
// Second dense layer: clamps six inputs, then one multiplier walks the six weights
// before a shifted, biased and saturated result is offered on a valid/ready port.
module nn_layer2_seq
    import nn_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int ACT_W = 9,
    parameter int W_W   = 10,
    parameter int OUT_W = 16,
    parameter int SHIFT = 2,
    parameter logic        [6*W_W-1:0] WEIGHTS = L2_WEIGHTS,
    parameter logic signed [OUT_W-1:0] BIAS    = L2_BIAS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in1,
    input  logic signed [IN_W-1:0]  in2,
    input  logic signed [IN_W-1:0]  in3,
    input  logic signed [IN_W-1:0]  in4,
    input  logic signed [IN_W-1:0]  in5,
    input  logic signed [IN_W-1:0]  in6,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out1
);

    localparam int ACC_W = ACT_W + W_W + 3;
    localparam int SUM_W = ACC_W + 1;

    state_t                    state_q;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic signed [OUT_W-1:0]   out1_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic        [2:0]         idx_q;
    logic signed [ACT_W-1:0]   act_q [6];

    logic signed [IN_W-1:0]    in_a  [6];
    logic signed [ACT_W-1:0]   act_d [6];
    logic signed [W_W-1:0]     w_a   [6];
    logic signed [ACC_W-1:0]   prod_d;
    logic signed [SUM_W-1:0]   sum_d;

    assign in_a = '{in1, in2, in3, in4, in5, in6};

    for (genvar k = 0; k < 6; k++) begin : g_lane
        nn_hardtanh #(
            .IN_W  (IN_W),
            .ACT_W (ACT_W)
        ) u_act (
            .x_i (in_a[k]),
            .y_o (act_d[k])
        );
        assign w_a[k] = WEIGHTS[k*W_W +: W_W];
    end

    // Operands are sign-extended to accumulator width before the multiply.
    assign prod_d = ACC_W'(act_q[idx_q]) * ACC_W'(w_a[idx_q]);
    assign sum_d  = SUM_W'(acc_q >>> SHIFT) + SUM_W'(BIAS);

    // NOTE: every register below uses <= so all next-state terms see the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out1_q      <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            // NOTE: the six-entry activation bank is reset too, so an abandoned
            // transaction leaves no stale operands behind.
            act_q       <= '{default: '0};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        act_q      <= act_d;
                        acc_q      <= '0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_q + prod_d;
                    if (idx_q == 3'd5)
                        state_q <= S_BIAS;
                    else
                        idx_q <= idx_q + 3'd1;
                end
                S_BIAS: begin
                    out1_q      <= sat16(sum_d);
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out1      = out1_q;

endmodule
